feature_frame_loader: RTL and testbench

Sequential front-end for the printed decision-tree classifiers. It receives one 8-bit quantized feature bit-serially from the sensor/ADC side and presents it as a glitch-free parallel word to the combinational tree. It waits a programmable settle time for the slow printed logic, then captures the tree's class code and offers it downstream over a valid/ready handshake.

---
 rtl/tree_if_pkg.sv | 19 +
 rtl/serial_shift_reg.sv | 25 ++
 rtl/feature_frame_loader.sv | 123 ++++++++++++
 tb/tb_feature_frame_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_if_pkg.sv
// Shared definitions for the printed-tree front-end and the generated tree tops.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tree_if_pkg;

  // Frame loader FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    SETTLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Default tree geometry, reused by the generated tree tops
  localparam int FEAT_W_DEF      = 8;
  localparam int CLASS_W_DEF     = 4;
  localparam int NUM_CLASSES_DEF = 10;

endpackage

// File: rtl/serial_shift_reg.sv
// Shadow shift register: collects serial bits MSB first, synchronous clear.
// Latency: one cycle per shifted bit; clr wins over en.
// Backpressure: none, shifts only when en is high.
// Ports: clk, rst (sync active-high), clr (sync clear), en (shift enable),
//        d (serial in), q (parallel contents, newest bit in q[0]).
module serial_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], d};
    end
  end

endmodule

// File: rtl/feature_frame_loader.sv
// Bit-serial feature loader for a combinational printed tree, with settle wait and class capture.
// Latency: FEAT_W+SETTLE_CYCLES cycles from the start edge to result_valid, +1 per sdi_valid stall.
// Backpressure: result held stable with result_valid high until result_ready; no new frame until then.
// Ports: clk, rst (sync active-high); start, sdi, sdi_valid (serial feature in);
//        x16 (parallel word to the tree), class_in (tree output);
//        result, result_err, result_valid / result_ready (downstream handshake); busy.
module feature_frame_loader
  import tree_if_pkg::*;
#(
  parameter int FEAT_W        = FEAT_W_DEF,
  parameter int CLASS_W       = CLASS_W_DEF,
  parameter int NUM_CLASSES   = NUM_CLASSES_DEF,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sdi,
  input  logic               sdi_valid,
  output logic [FEAT_W-1:0]  x16,
  input  logic [CLASS_W-1:0] class_in,
  output logic [CLASS_W-1:0] result,
  output logic               result_err,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy
);

  localparam int BCNT_W = $clog2(FEAT_W + 1);
  localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t              state;
  logic [BCNT_W-1:0]   bcnt;
  logic [SCNT_W-1:0]   scnt;
  logic [FEAT_W-1:0]   shadow;
  logic                sh_clr;
  logic                sh_en;
  logic                last_bit;

  // Shadow control: a start in IDLE or SHIFT clears it, and start beats sdi_valid
  // so the bit presented on a restart cycle is dropped.
  always_comb begin
    sh_clr = 1'b0;
    sh_en  = 1'b0;
    case (state)
      IDLE:  sh_clr = start;
      SHIFT: begin
        sh_clr = start;
        sh_en  = !start && sdi_valid;
      end
      default: ;
    endcase
  end

  serial_shift_reg #(
    .W (FEAT_W)
  ) u_shadow (
    .clk (clk),
    .rst (rst),
    .clr (sh_clr),
    .en  (sh_en),
    .d   (sdi),
    .q   (shadow)
  );

  assign last_bit = (bcnt == BCNT_W'(FEAT_W - 1));
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bcnt         <= '0;
      scnt         <= '0;
      x16          <= '0;
      result       <= '0;
      result_err   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            bcnt  <= '0;
          end
        end
        SHIFT: begin
          if (start) begin
            bcnt <= '0;
          end else if (sdi_valid) begin
            if (last_bit) begin
              // The shadow does not yet hold this bit, so splice it in;
              // the oldest shadow bit falls off the top.
              x16   <= FEAT_W'({shadow, sdi});
              scnt  <= SCNT_W'(SETTLE_CYCLES - 1);
              bcnt  <= '0;
              state <= SETTLE;
            end else begin
              bcnt <= bcnt + BCNT_W'(1);
            end
          end
        end
        SETTLE: begin
          if (scnt != '0) begin
            scnt <= scnt - SCNT_W'(1);
          end else begin
            result       <= class_in;
            result_err   <= (int'(class_in) >= NUM_CLASSES);
            result_valid <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_frame_loader.sv
// Directed bench for feature_frame_loader with a result scoreboard.
module tb_feature_frame_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sdi;
  logic       sdi_valid;
  logic [7:0] x16;
  logic [3:0] class_in;
  logic [3:0] result;
  logic       result_err;
  logic       result_valid;
  logic       result_ready;
  logic       busy;

  feature_frame_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sdi          (sdi),
    .sdi_valid    (sdi_valid),
    .x16          (x16),
    .class_in     (class_in),
    .result       (result),
    .result_err   (result_err),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int e0    = 0;

  typedef struct {
    logic [7:0] x;
    logic [3:0] res;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] x, input logic [3:0] res, input logic err, input int lat);
    exp_t e;
    e.x   = x;
    e.res = res;
    e.err = err;
    e.lat = lat;
    sbq.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic vld, input logic b);
    start     = 1'b1;
    sdi_valid = vld;
    sdi       = b;
    step();
    e0        = cyc;
    start     = 1'b0;
    sdi_valid = 1'b0;
  endtask

  // Shifts n bits of w MSB first; optional stall of stall_len cycles before bit stall_at.
  // stable reports whether x16 held its old value until the completing bit.
  task automatic shift_bits(input logic [7:0] w, input int n, input int stall_at,
                            input int stall_len, output logic stable);
    logic [7:0] old;
    old    = x16;
    stable = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          sdi_valid = 1'b0;
          step();
          if (x16 !== old) stable = 1'b0;
        end
      end
      sdi       = w[7-i];
      sdi_valid = 1'b1;
      step();
      if (i != 7 && x16 !== old) stable = 1'b0;
    end
    sdi_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 60) begin
      step();
      k++;
    end
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic run_frame(input logic [7:0] w, input logic [3:0] cls, input string name);
    logic st;
    class_in = cls;
    do_start(1'b0, 1'b0);
    shift_bits(w, 8, -1, 0, st);
    chk({name, "_x16"}, x16, w);
    wait_idle(name);
  endtask

  // Monitor: records the valid rise cycle and checks each accepted result against the queue.
  initial begin
    int   rise;
    logic pv;
    exp_t e;
    rise = 0;
    pv   = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1 && pv !== 1'b1) rise = cyc;
      pv = result_valid;
      if (result_valid === 1'b1 && result_ready === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("result", result, e.res);
          chk("result_err", result_err, e.err);
          chk("x16_at_result", x16, e.x);
          chk("latency", rise - e0, e.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st;
    logic st2;
    logic hold_ok;
    int   k;

    rst          = 1'b1;
    start        = 1'b0;
    sdi          = 1'b0;
    sdi_valid    = 1'b0;
    class_in     = 4'd0;
    result_ready = 1'b1;
    repeat (3) step();
    chk("rst_x16", x16, 0);
    chk("rst_result", result, 0);
    chk("rst_err", result_err, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Basic frame
    class_in = 4'd7;
    push_exp(8'hB4, 4'd7, 1'b0, 12);
    do_start(1'b0, 1'b0);
    chk("basic_busy_e1", busy, 1);
    shift_bits(8'hB4, 8, -1, 0, st);
    chk("basic_x16_e8", x16, 8'hB4);
    chk("basic_x16_stable", st, 1);
    chk("basic_busy_e8", busy, 1);
    wait_idle("basic");

    // Stall: 3 idle cycles after bit 4
    push_exp(8'hB4, 4'd7, 1'b0, 15);
    do_start(1'b0, 1'b0);
    shift_bits(8'hB4, 8, 4, 3, st);
    chk("stall_x16_e11", x16, 8'hB4);
    chk("stall_x16_stable", st, 1);
    wait_idle("stall");

    // Restart after 5 ones; restart cycle presents a valid 1 that must be dropped
    class_in = 4'd5;
    push_exp(8'h3C, 4'd5, 1'b0, 12);
    do_start(1'b0, 1'b0);
    shift_bits(8'hF8, 5, -1, 0, st);
    do_start(1'b1, 1'b1);
    shift_bits(8'h3C, 8, -1, 0, st2);
    chk("restart_x16", x16, 8'h3C);
    chk("restart_partial_hidden", st && st2, 1);
    wait_idle("restart");

    // Backpressure in HOLD with start and class_in changes
    result_ready = 1'b0;
    class_in     = 4'd7;
    push_exp(8'hB4, 4'd7, 1'b0, 12);
    do_start(1'b0, 1'b0);
    shift_bits(8'hB4, 8, -1, 0, st);
    k = 0;
    while (result_valid !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    chk("bp_valid_up", result_valid, 1);
    hold_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      class_in = 4'd2;
      start    = (i == 2);
      step();
      start = 1'b0;
      if (result !== 4'd7 || result_valid !== 1'b1 || x16 !== 8'hB4) hold_ok = 1'b0;
    end
    chk("bp_hold_stable", hold_ok, 1);
    result_ready = 1'b1;
    start        = 1'b1;
    step();
    start = 1'b0;
    chk("bp_valid_drop", result_valid, 0);
    chk("bp_idle_start_ignored", busy, 0);

    // Illegal class then legal boundary class
    push_exp(8'h5A, 4'd12, 1'b1, 12);
    run_frame(8'h5A, 4'd12, "illegal");
    push_exp(8'hA5, 4'd9, 1'b0, 12);
    run_frame(8'hA5, 4'd9, "legal9");

    // Reset during SETTLE, then a fresh frame
    class_in = 4'd3;
    do_start(1'b0, 1'b0);
    shift_bits(8'h81, 8, -1, 0, st);
    step();
    rst = 1'b1;
    step();
    chk("midrst_x16", x16, 0);
    chk("midrst_result", result, 0);
    chk("midrst_err", result_err, 0);
    chk("midrst_valid", result_valid, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    step();
    push_exp(8'h66, 4'd3, 1'b0, 12);
    run_frame(8'h66, 4'd3, "after_rst");

    repeat (3) step();
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
